mem_fill_responder: RTL and testbench

Memory-side responder for the cache-miss fill protocol: serves block-fill requests from the instruction cache and the data cache, plus single-word write-throughs from the data cache, out of one shared 16-bit-word backing array. It returns each block as a pipelined stream of words, each marked with a data-valid strobe and a word index. It sits between both caches' miss ports and main memory, replacing the per-cache `memory4c` instances.

---
 rtl/mem_fill_responder.sv | 115 +++++++++++
 tb/tb_mem_fill_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: shared-array block-fill / write-through responder for the I- and D-cache miss ports.
// Define FILL_CRITICAL_WORD_FIRST_EN to start each burst at the missed word and wrap within the block.
module mem_fill_responder #(
    parameter int DEPTH_WORDS = 32768,
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_valid,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_data,
    output logic        d_valid,
    output logic        d_done,
    output logic [2:0]  fill_idx
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PL = LATENCY - 1;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] base, waddr, i_word, d_word;
    logic [15:0]   wr_data;
    logic [2:0]    cnt, start, cur;
    logic          owner;
    logic [15:0]   mem [DEPTH_WORDS];
    logic [15:0]   pd [PL];
    logic          pv [PL];
    logic          pown [PL];
    logic          plast [PL];
    logic [2:0]    pidx [PL];
    logic          unused_addr;

    assign i_word      = i_addr[AW:1];
    assign d_word      = d_addr[AW:1];
    assign cur         = start + cnt;
    assign unused_addr = ^{i_addr, d_addr};

    // Array and read-data pipeline carry no reset; validity travels in the reset pipeline below.
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[waddr] <= wr_data;
        pd[0] <= mem[{base[AW-1:3], cur}];
        for (int i = 1; i < PL; i++) pd[i] <= pd[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            owner    <= 1'b0;
            for (int i = 0; i < PL; i++) pv[i] <= 1'b0;
            i_valid  <= 1'b0;
            d_valid  <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            i_data   <= 16'd0;
            d_data   <= 16'd0;
            fill_idx <= 3'd0;
        end else begin
            if (state == IDLE) begin
                cnt <= 3'd0;
                if (d_req) begin
                    owner   <= 1'b1;
                    state   <= d_wr ? WRITE : ISSUE;
                    base    <= d_word;
                    start   <= CWF ? d_addr[3:1] : 3'd0;
                    waddr   <= d_word;
                    wr_data <= d_wdata;
                end else if (i_req) begin
                    owner <= 1'b0;
                    state <= ISSUE;
                    base  <= i_word;
                    start <= CWF ? i_addr[3:1] : 3'd0;
                end
            end else if (state == WRITE) begin
                state <= IDLE;
            end else if (state == ISSUE) begin
                cnt <= cnt + 3'd1;
                if (cnt == 3'(BLOCK_WORDS - 1)) state <= DRAIN;
            end else if (i_done || d_done) begin
                state <= IDLE;
            end
            pv[0]    <= state == ISSUE;
            pown[0]  <= owner;
            pidx[0]  <= cur;
            plast[0] <= cnt == 3'(BLOCK_WORDS - 1);
            for (int i = 1; i < PL; i++) begin
                pv[i]    <= pv[i-1];
                pown[i]  <= pown[i-1];
                pidx[i]  <= pidx[i-1];
                plast[i] <= plast[i-1];
            end
            i_valid  <= pv[PL-1] && !pown[PL-1];
            d_valid  <= pv[PL-1] && pown[PL-1];
            i_done   <= pv[PL-1] && !pown[PL-1] && plast[PL-1];
            d_done   <= (state == IDLE && d_req && d_wr) || (pv[PL-1] && pown[PL-1] && plast[PL-1]);
            i_data   <= (pv[PL-1] && !pown[PL-1]) ? pd[PL-1] : 16'd0;
            d_data   <= (pv[PL-1] && pown[PL-1]) ? pd[PL-1] : 16'd0;
            fill_idx <= pv[PL-1] ? pidx[PL-1] : 3'd0;
        end
    end
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed + randomized checks of mem_fill_responder against a word-array model.
// Honours FILL_CRITICAL_WORD_FIRST_EN when computing the expected burst order.
module tb_mem_fill_responder;
    localparam int DEPTH = 32768;
    localparam int L     = 4;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = 16'd0, d_addr = 16'd0, d_wdata = 16'd0;
    logic [15:0] i_data, d_data;
    logic        i_valid, i_done, d_valid, d_done;
    logic [2:0]  fill_idx;
    int          checks = 0, errors = 0;
    logic [15:0] model [int];

    mem_fill_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L), .BLOCK_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_data(d_data), .d_valid(d_valid), .d_done(d_done), .fill_idx(fill_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_i_valid"}, i_valid, 0);
        chk({tag, "_d_valid"}, d_valid, 0);
        chk({tag, "_i_done"}, i_done, 0);
        chk({tag, "_d_done"}, d_done, 0);
        chk({tag, "_i_data"}, i_data, 0);
        chk({tag, "_d_data"}, d_data, 0);
        chk({tag, "_fill_idx"}, fill_idx, 0);
    endtask

    function automatic int wbase(input logic [15:0] a);
        return int'(a[15:1]) & (DEPTH - 1) & ~7;
    endfunction

    function automatic int wstart(input logic [15:0] a);
        return CWF ? int'(a[3:1]) : 0;
    endfunction

    // Single-word write: done in the cycle after the request, request dropped the cycle after that.
    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        d_req = 1'b1; d_wr = 1'b1; d_addr = a; d_wdata = v;
        @(negedge clk); chk("wr_c0_d_done", d_done, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("wr_d_done", d_done, 1); chk("wr_d_valid", d_valid, 0);
        @(posedge clk); #1;
        d_req = 1'b0; d_wr = 1'b0;
        model[int'(a[15:1]) & (DEPTH - 1)] = v;
    endtask

    task automatic preload(input int b);
        for (int k = 0; k < 8; k++)
            if (!model.exists(b + k)) wr(16'((b + k) << 1), 16'(32'hA000 + b + k));
    endtask

    // Cycle t = 0 is the IDLE cycle where the request(s) become visible; I follows a D fill at 9+L.
    task automatic fill(input bit ud, input bit ui, input logic [15:0] da, input logic [15:0] ia);
        int io, last, bd, sd, bi, si;
        io = ud ? 9 + L : 0;
        last = (ui ? io : 0) + 9 + L;
        bd = wbase(da); sd = wstart(da); bi = wbase(ia); si = wstart(ia);
        d_req = ud; d_wr = 1'b0; d_addr = da; i_req = ui; i_addr = ia;
        for (int t = 0; t <= last; t++) begin
            bit vd, vi;
            int kd, ki;
            logic [2:0] xd, xi;
            kd = t - L - 1;
            ki = t - io - L - 1;
            vd = ud && kd >= 0 && kd < 8;
            vi = ui && ki >= 0 && ki < 8;
            xd = 3'((sd + kd) & 7);
            xi = 3'((si + ki) & 7);
            @(negedge clk);
            chk("d_valid", d_valid, vd);
            chk("d_done", d_done, vd && kd == 7);
            chk("d_data", d_data, vd ? model[bd + xd] : 16'd0);
            chk("i_valid", i_valid, vi);
            chk("i_done", i_done, vi && ki == 7);
            chk("i_data", i_data, vi ? model[bi + xi] : 16'd0);
            chk("fill_idx", fill_idx, vd ? xd : vi ? xi : 3'd0);
            @(posedge clk); #1;
            if (ud && kd == 7) d_req = 1'b0;
            if (ui && ki == 7) i_req = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a, b;
        int m;
        repeat (2) @(posedge clk);
        #1; zero_chk("reset");
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; zero_chk("post_reset"); end

        preload(wbase(16'h0036));
        fill(1'b0, 1'b1, 16'h0000, 16'h0036);

        preload(wbase(16'h0100));
        fill(1'b1, 1'b1, 16'h0100, 16'h0036);

        preload(wbase(16'h0040));
        wr(16'h0040, 16'hBEEF);
        fill(1'b1, 1'b0, 16'h0040, 16'h0000);

        i_addr = 16'h0036; i_req = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0; i_req = 1'b0;
        @(posedge clk); #1; zero_chk("rst_mid_a");
        @(posedge clk); #1; zero_chk("rst_mid_b");
        rst_n = 1'b1;
        repeat (L + 8) begin @(posedge clk); #1; zero_chk("rst_mid_post"); end
        fill(1'b0, 1'b1, 16'h0000, 16'h0036);

        preload(wbase(16'hFFFE));
        fill(1'b0, 1'b1, 16'h0000, 16'hFFFE);

        for (int n = 0; n < 8; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            m = int'($urandom_range(0, 2));
            preload(wbase(a));
            preload(wbase(b));
            wr({a[15:4], 3'($urandom), 1'($urandom)}, 16'($urandom));
            fill(m != 1, m != 0, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
